// File: rtl/ccd_sharp_pkg.sv
// Shared definitions for the Sharp CCD timing generator, sensor model and capture stage:
// FSM states, vertical transfer step patterns and readout geometry helpers.
package ccd_sharp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SG,
    ST_VSHIFT,
    ST_HGAP,
    ST_HREAD,
    ST_DONE
  } state_e;

  localparam logic [3:0] XV_IDLE = 4'b1100;
  localparam logic [3:0] XV_S1   = 4'b0110;
  localparam logic [3:0] XV_S2   = 4'b0011;
  localparam logic [3:0] XV_S3   = 4'b1001;

  function automatic int unsigned pix_total(input int unsigned dummy_front,
                                            input int unsigned black_front,
                                            input int unsigned active,
                                            input int unsigned black_rear,
                                            input int unsigned dummy_rear);
    return dummy_front + black_front + active + black_rear + dummy_rear;
  endfunction

  function automatic int unsigned line_total(input int unsigned dummy_front,
                                             input int unsigned black_front,
                                             input int unsigned active,
                                             input int unsigned black_rear,
                                             input int unsigned dummy_rear);
    return dummy_front + black_front + active + black_rear + dummy_rear;
  endfunction

  // A vertical shift walks S1, S2, S3 and lands back on the idle pattern.
  function automatic logic [3:0] xv_pattern(input logic [1:0] step);
    case (step)
      2'd0:    return XV_S1;
      2'd1:    return XV_S2;
      2'd2:    return XV_S3;
      default: return XV_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ccd_sharp_hclk_gen.sv
// Horizontal readout clocking: two clocks per pixel (reset-gate phase A, transfer phase B),
// with a pixel index and an end-of-line flag raised during the last phase B.
module ccd_sharp_hclk_gen #(
  parameter int unsigned PIX_TOTAL = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  output logic        h1_o,
  output logic        h2_o,
  output logic        hl_o,
  output logic        rs_o,
  output logic        lval_o,
  output logic [15:0] pix_cnt_o,
  output logic        line_end_o
);

  localparam logic [15:0] PIX_LAST = 16'(PIX_TOTAL - 1);

  logic        run_q;
  logic        phase_a_q, phase_a_d;
  logic [15:0] pix_q, pix_d;

  // run_i already reflects the next cycle, so these registers line up with the frame outputs.
  always_comb begin
    phase_a_d = 1'b0;
    pix_d     = '0;
    if (run_i) begin
      if (run_q && phase_a_q) begin
        phase_a_d = 1'b0;
        pix_d     = pix_q;
      end else if (run_q) begin
        phase_a_d = 1'b1;
        pix_d     = pix_q + 16'd1;
      end else begin
        phase_a_d = 1'b1;
        pix_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= 1'b0;
      phase_a_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      run_q     <= run_i;
      phase_a_q <= phase_a_d;
      pix_q     <= pix_d;
    end
  end

  assign h1_o       = ~phase_a_q;
  assign hl_o       = ~phase_a_q;
  assign h2_o       = phase_a_q;
  assign rs_o       = phase_a_q;
  assign lval_o     = phase_a_q;
  assign pix_cnt_o  = pix_q;
  assign line_end_o = run_q && !phase_a_q && (pix_q == PIX_LAST);

endmodule

// File: rtl/ccd_sharp_timing_gen.sv
// Frame-level timing generator for the Sharp CCD: sensor-gate pulse, per-line vertical
// transfer, horizontal readout and frame/line/pixel qualifiers for the capture stage.
module ccd_sharp_timing_gen
  import ccd_sharp_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 32,
  parameter int unsigned IMAGE_HEIGHT = 8,
  parameter int unsigned BLACK_HFRONT = 2,
  parameter int unsigned BLACK_HREAR  = 2,
  parameter int unsigned DUMMY_HFRONT = 2,
  parameter int unsigned DUMMY_HREAR  = 2,
  parameter int unsigned BLACK_VFRONT = 1,
  parameter int unsigned BLACK_VREAR  = 1,
  parameter int unsigned DUMMY_VFRONT = 1,
  parameter int unsigned DUMMY_VREAR  = 1,
  parameter int unsigned V_STEP_CYC   = 4,
  parameter int unsigned XSG_CYC      = 8,
  parameter int unsigned H_GAP_CYC    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  output logic        xv1,
  output logic        xv2,
  output logic        xv3,
  output logic        xv4,
  output logic        xsg,
  output logic        hl,
  output logic        h1,
  output logic        h2,
  output logic        rs,
  output logic        o_fval,
  output logic        o_lval,
  output logic [15:0] ov_line_cnt,
  output logic [15:0] ov_pix_cnt,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int unsigned PIX_TOTAL  = pix_total(DUMMY_HFRONT, BLACK_HFRONT, IMAGE_WIDTH,
                                                 BLACK_HREAR, DUMMY_HREAR);
  localparam int unsigned LINE_TOTAL = line_total(DUMMY_VFRONT, BLACK_VFRONT, IMAGE_HEIGHT,
                                                  BLACK_VREAR, DUMMY_VREAR);
  localparam logic [15:0] XSG_LAST   = 16'(XSG_CYC - 1);
  localparam logic [15:0] VSTEP_LAST = 16'(V_STEP_CYC - 1);
  localparam logic [15:0] HGAP_LAST  = 16'(H_GAP_CYC - 1);
  localparam logic [15:0] LINE_LAST  = 16'(LINE_TOTAL - 1);

  if (PIX_TOTAL > 65535 || LINE_TOTAL > 65535 || IMAGE_WIDTH < 1 || IMAGE_HEIGHT < 1 ||
      V_STEP_CYC < 1 || XSG_CYC < 1 || XSG_CYC > 65536 || V_STEP_CYC > 65536 ||
      H_GAP_CYC > 65536) begin : g_bad_params
    $error("ccd_sharp_timing_gen: illegal geometry or timing parameters");
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] line_q, line_d;
  logic [3:0]  xv_q;
  logic        xsg_q, fval_q, busy_q, done_q;
  logic        line_end;
  logic        run;

  // cnt counts clocks spent in the current state/step and restarts on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    step_d  = step_q;
    line_d  = line_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        step_d = '0;
        line_d = '0;
        if (i_start) state_d = ST_SG;
      end
      ST_SG: begin
        if (cnt_q == XSG_LAST) begin
          state_d = ST_VSHIFT;
          cnt_d   = '0;
          step_d  = '0;
          line_d  = '0;
        end
      end
      ST_VSHIFT: begin
        if (cnt_q == VSTEP_LAST) begin
          cnt_d  = '0;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) state_d = (H_GAP_CYC == 0) ? ST_HREAD : ST_HGAP;
        end
      end
      ST_HGAP: begin
        if (cnt_q == HGAP_LAST) begin
          state_d = ST_HREAD;
          cnt_d   = '0;
        end
      end
      ST_HREAD: begin
        cnt_d = '0;
        if (line_end) begin
          step_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_VSHIFT;
            line_d  = line_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        line_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      line_q  <= '0;
      xv_q    <= XV_IDLE;
      xsg_q   <= 1'b1;
      fval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      line_q  <= line_d;
      xv_q    <= (state_d == ST_VSHIFT) ? xv_pattern(step_d) : XV_IDLE;
      xsg_q   <= (state_d != ST_SG);
      fval_q  <= (state_d != ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign run = (state_d == ST_HREAD);

  ccd_sharp_hclk_gen #(
    .PIX_TOTAL(PIX_TOTAL)
  ) u_hclk (
    .clk       (clk),
    .reset     (reset),
    .run_i     (run),
    .h1_o      (h1),
    .h2_o      (h2),
    .hl_o      (hl),
    .rs_o      (rs),
    .lval_o    (o_lval),
    .pix_cnt_o (ov_pix_cnt),
    .line_end_o(line_end)
  );

  assign {xv1, xv2, xv3, xv4} = xv_q;
  assign xsg          = xsg_q;
  assign o_fval       = fval_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign ov_line_cnt  = line_q;

endmodule

// File: tb/tb_ccd_sharp_timing_gen.sv
// Scoreboard bench for ccd_sharp_timing_gen: default geometry on instance A, and
// DUMMY_VFRONT=0 / H_GAP_CYC=0 on instance B.
module tb_ccd_sharp_timing_gen;

  localparam logic [12:0] IDLE_VEC = 13'b1100_1_1_1_0_0_0_0_0_0;
  localparam int FULL = 1 << 30;

  typedef struct {
    int cycle;
    bit isDone;
    int line;
    int pix;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetA, startA, resetB, startB;
  logic xv1A, xv2A, xv3A, xv4A, xsgA, hlA, h1A, h2A, rsA, fvalA, lvalA, busyA, doneA;
  logic xv1B, xv2B, xv3B, xv4B, xsgB, hlB, h1B, h2B, rsB, fvalB, lvalB, busyB, doneB;
  logic [15:0] lineA, pixA, lineB, pixB;
  logic [12:0] vecA, vecB;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int hErrA = 0;
  int hErrB = 0;
  ev_t qA[$];
  ev_t qB[$];

  ccd_sharp_timing_gen dutA (
    .clk(clk), .reset(resetA), .i_start(startA),
    .xv1(xv1A), .xv2(xv2A), .xv3(xv3A), .xv4(xv4A), .xsg(xsgA),
    .hl(hlA), .h1(h1A), .h2(h2A), .rs(rsA),
    .o_fval(fvalA), .o_lval(lvalA), .ov_line_cnt(lineA), .ov_pix_cnt(pixA),
    .o_busy(busyA), .o_frame_done(doneA)
  );

  ccd_sharp_timing_gen #(.DUMMY_VFRONT(0), .H_GAP_CYC(0)) dutB (
    .clk(clk), .reset(resetB), .i_start(startB),
    .xv1(xv1B), .xv2(xv2B), .xv3(xv3B), .xv4(xv4B), .xsg(xsgB),
    .hl(hlB), .h1(h1B), .h2(h2B), .rs(rsB),
    .o_fval(fvalB), .o_lval(lvalB), .ov_line_cnt(lineB), .ov_pix_cnt(pixB),
    .o_busy(busyB), .o_frame_done(doneB)
  );

  assign vecA = {xv1A, xv2A, xv3A, xv4A, xsgA, h1A, hlA, h2A, rsA, fvalA, lvalA, busyA, doneA};
  assign vecB = {xv1B, xv2B, xv3B, xv4B, xsgB, h1B, hlB, h2B, rsB, fvalB, lvalB, busyB, doneB};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 40000) begin
      $display("[TB] FAIL watchdog cyc=%0d required below 40000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cyc=%0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Expected pixel and frame-done events for one frame; events after lastCycle are dropped.
  task automatic pushFrame(input bit toB, input int s, input int lines, input int period,
                           input int gap, input int lastCycle);
    ev_t e;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < 40; p++) begin
        e.cycle  = s + 8 + l * period + 16 + gap + 2 * p;
        e.isDone = 1'b0;
        e.line   = l;
        e.pix    = p;
        if (e.cycle <= lastCycle) begin
          if (toB) qB.push_back(e);
          else qA.push_back(e);
        end
      end
    end
    e.cycle  = s + 8 + lines * period;
    e.isDone = 1'b1;
    e.line   = 0;
    e.pix    = 0;
    if (e.cycle <= lastCycle) begin
      if (toB) qB.push_back(e);
      else qA.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit toB, input int lines, input int period, input int gap,
                               input int limitOff, output int s);
    if (toB) startB = 1'b1;
    else startA = 1'b1;
    s = cyc + 1;
    pushFrame(toB, s, lines, period, gap, s + limitOff);
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic popCheck(input bit isB);
    ev_t e;
    bit dn;
    int ln, px, qs;
    dn = isB ? doneB : doneA;
    ln = isB ? int'(lineB) : int'(lineA);
    px = isB ? int'(pixB) : int'(pixA);
    if (dn) begin
      ln = 0;
      px = 0;
    end
    qs = isB ? qB.size() : qA.size();
    total++;
    if (qs == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_output dut=%s cyc=%0d done=%0d line=%0d pix=%0d required none",
               isB ? "B" : "A", cyc, dn, ln, px);
    end else begin
      if (isB) e = qB.pop_front();
      else e = qA.pop_front();
      if (e.cycle != cyc || e.isDone != dn || e.line != ln || e.pix != px) begin
        bad++;
        $display("[TB] FAIL scoreboard dut=%s actual cyc=%0d done=%0d line=%0d pix=%0d required cyc=%0d done=%0d line=%0d pix=%0d",
                 isB ? "B" : "A", cyc, dn, ln, px, e.cycle, e.isDone, e.line, e.pix);
      end
    end
  endtask

  // Monitors: every lval or frame-done presented by a DUT consumes one expected event.
  always @(negedge clk) begin
    if (h2A !== ~h1A || hlA !== h1A) hErrA++;
    if (lvalA === 1'b1 || doneA === 1'b1) popCheck(1'b0);
  end

  always @(negedge clk) begin
    if (h2B !== ~h1B || hlB !== h1B) hErrB++;
    if (lvalB === 1'b1 || doneB === 1'b1) popCheck(1'b1);
  end

  initial begin
    int s, r;
    resetA = 1'b1;
    resetB = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vec_A", vecA, IDLE_VEC);
    checkOutput("reset_cnt_A", {lineA, pixA}, 32'd0);
    checkOutput("reset_vec_B", vecB, IDLE_VEC);
    resetA = 1'b0;
    resetB = 1'b0;
    @(negedge clk);
    checkOutput("idle_vec_A", vecA, IDLE_VEC);

    $display("[TB] single frame with ignored mid-frame start");
    applyStimulus(1'b0, 12, 98, 2, FULL, s);
    checkOutput("start_busy_fval_xsg", {busyA, fvalA, xsgA}, 3'b110);
    waitCycle(s + 7);
    checkOutput("xsg_low_last", xsgA, 1'b0);
    waitCycle(s + 8);
    checkOutput("vshift_s1", {xsgA, xv1A, xv2A, xv3A, xv4A, lineA}, {1'b1, 4'b0110, 16'd0});
    waitCycle(s + 12);
    checkOutput("vshift_s2", {xv1A, xv2A, xv3A, xv4A}, 4'b0011);
    waitCycle(s + 16);
    checkOutput("vshift_s3", {xv1A, xv2A, xv3A, xv4A}, 4'b1001);
    waitCycle(s + 20);
    checkOutput("vshift_s4", {xv1A, xv2A, xv3A, xv4A}, 4'b1100);
    waitCycle(s + 24);
    checkOutput("hgap_idle", {xv1A, xv2A, xv3A, xv4A, h1A, rsA, lvalA}, 7'b1100_1_0_0);
    waitCycle(s + 26);
    checkOutput("pix0_phase_a", {h1A, h2A, rsA, lvalA, pixA}, {4'b0111, 16'd0});
    waitCycle(s + 27);
    checkOutput("pix0_phase_b", {h1A, h2A, rsA, lvalA, pixA}, {4'b1000, 16'd0});
    waitCycle(s + 106);
    checkOutput("line1_vshift", {xv1A, xv2A, xv3A, xv4A, lineA}, {4'b0110, 16'd1});
    waitCycle(s + 8 + 5 * 98 + 30);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitCycle(s + 1184);
    checkOutput("done_clock", {doneA, busyA, fvalA, lineA}, {3'b111, 16'd11});
    waitCycle(s + 1185);
    checkOutput("after_done_vec", vecA, IDLE_VEC);
    checkOutput("after_done_line", lineA, 16'd0);
    waitCycle(s + 1195);
    checkOutput("no_queued_frame", busyA, 1'b0);

    $display("[TB] reset during line 3 readout");
    applyStimulus(1'b0, 12, 98, 2, 8 + 3 * 98 + 40, s);
    r = s + 8 + 3 * 98 + 40;
    waitCycle(r);
    checkOutput("pre_abort_line", {lineA, lvalA}, {16'd3, 1'b1});
    resetA = 1'b1;
    @(negedge clk);
    checkOutput("abort_vec", vecA, IDLE_VEC);
    checkOutput("abort_cnt", {lineA, pixA}, 32'd0);
    resetA = 1'b0;
    waitCycle(cyc + 20);
    checkOutput("abort_stays_idle", busyA, 1'b0);
    applyStimulus(1'b0, 12, 98, 2, FULL, s);
    waitCycle(s + 1185);
    checkOutput("post_abort_frame_end", vecA, IDLE_VEC);

    $display("[TB] start held high");
    startA = 1'b1;
    s = cyc + 1;
    pushFrame(1'b0, s, 12, 98, 2, FULL);
    pushFrame(1'b0, s + 1186, 12, 98, 2, FULL);
    waitCycle(s + 1184);
    checkOutput("b2b_done1", {doneA, busyA}, 2'b11);
    waitCycle(s + 1185);
    checkOutput("b2b_gap_idle", {busyA, fvalA}, 2'b00);
    waitCycle(s + 1186);
    checkOutput("b2b_restart", {busyA, xsgA}, 2'b10);
    waitCycle(s + 1190);
    startA = 1'b0;
    waitCycle(s + 2 * 1186 + 3);
    checkOutput("b2b_final_idle", busyA, 1'b0);

    $display("[TB] no front dummy line, no horizontal gap");
    applyStimulus(1'b1, 11, 96, 0, FULL, s);
    waitCycle(s + 8 + 15);
    checkOutput("B_last_vstep", {xv1B, xv2B, xv3B, xv4B, lvalB}, 5'b1100_0);
    waitCycle(s + 8 + 16);
    checkOutput("B_first_pixel", {xv1B, xv2B, xv3B, xv4B, h1B, lvalB, pixB}, {6'b1100_0_1, 16'd0});
    waitCycle(s + 8 + 96);
    checkOutput("B_line1_vshift", {xv1B, xv2B, xv3B, xv4B, lineB}, {4'b0110, 16'd1});
    waitCycle(s + 1064);
    checkOutput("B_done", {doneB, lineB}, {1'b1, 16'd10});
    waitCycle(s + 1065);
    checkOutput("B_idle", vecB, IDLE_VEC);

    waitCycle(cyc + 5);
    checkOutput("queueA_drained", qA.size(), 0);
    checkOutput("queueB_drained", qB.size(), 0);
    checkOutput("h_invariant_A", hErrA, 0);
    checkOutput("h_invariant_B", hErrB, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccd_sharp_timing_gen.md
Name: ccd_sharp_timing_gen

Overview:
- Synthesizable vertical/horizontal timing generator for the Sharp CCD sensor.
- Drives xv1..xv4, xsg, hl, h1, h2 and rs into the CCD sensor model / AFE path.
- Also gives the downstream pixel-capture stage frame, line and pixel qualifiers.
- One frame is read out per start request, using the same dummy/black/active geometry parameters as the sensor model.

Parameters:
IMAGE_WIDTH, 32, active pixels per line
IMAGE_HEIGHT, 8, active lines per frame
BLACK_HFRONT, 2, optical-black pixels before active area
BLACK_HREAR, 2, optical-black pixels after active area
DUMMY_HFRONT, 2, dummy pixels at line start
DUMMY_HREAR, 2, dummy pixels at line end
BLACK_VFRONT, 1, black lines before active area
BLACK_VREAR, 1, black lines after active area
DUMMY_VFRONT, 1, dummy lines at frame start
DUMMY_VREAR, 1, dummy lines at frame end
V_STEP_CYC, 4, clocks per vertical-transfer phase step
XSG_CYC, 8, clocks xsg is held low
H_GAP_CYC, 2, clocks between end of vertical shift and first pixel

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_start  input  1  frame request; sampled only in IDLE
xv1  output  1  vertical clock phase 1
xv2  output  1  vertical clock phase 2
xv3  output  1  vertical clock phase 3
xv4  output  1  vertical clock phase 4
xsg  output  1  sensor gate, active low
hl  output  1  last-stage horizontal clock, equals h1
h1  output  1  horizontal clock 1
h2  output  1  horizontal clock 2, always ~h1
rs  output  1  reset-gate pulse
o_fval  output  1  frame valid
o_lval  output  1  pixel valid, one per pixel
ov_line_cnt  output  16  current line index, 0-based
ov_pix_cnt  output  16  current pixel index, 0-based
o_busy  output  1  high when not IDLE
o_frame_done  output  1  one-clock pulse at end of frame

Behaviour:
- Derived constants:
  - PIX_TOTAL = DUMMY_HFRONT+BLACK_HFRONT+IMAGE_WIDTH+BLACK_HREAR+DUMMY_HREAR; 40 with defaults.
  - LINE_TOTAL = sum of the five vertical terms; 12 with defaults.
- All outputs are registered. Outputs after reset, and on returning to IDLE:
  - {xv1,xv2,xv3,xv4}=4'b1100, xsg=1, h1=hl=1, h2=0, rs=0.
  - o_fval=o_lval=o_busy=o_frame_done=0, counters=0.
- States: IDLE -> SG -> VSHIFT -> HGAP -> HREAD -> (VSHIFT | DONE) -> IDLE.
- IDLE: when i_start=1, go to SG on the next clock; o_busy and o_fval rise on that same clock edge.
- SG:
  - xsg=0 for exactly XSG_CYC clocks; xv held at 1100.
  - Then go to VSHIFT with ov_line_cnt=0.
- VSHIFT:
  - Four steps of V_STEP_CYC clocks each, patterns 0110, 0011, 1001, 1100 in that order.
  - Ends at the idle pattern. h1/h2/rs hold idle values.
- HGAP: H_GAP_CYC clocks, all clocks idle.
- HREAD: 2 clocks per pixel.
  - Phase A: h1=hl=0, h2=1, rs=1.
  - Phase B: h1=hl=1, h2=0, rs=0.
  - o_lval=1 in phase A only; ov_pix_cnt holds the pixel index 0..PIX_TOTAL-1 for both phases.
  - After the last phase B: if ov_line_cnt=LINE_TOTAL-1 go to DONE, else increment ov_line_cnt and go to VSHIFT.
- Line period = 4*V_STEP_CYC + H_GAP_CYC + 2*PIX_TOTAL; 98 clocks with defaults.
- DONE: one clock. o_frame_done=1, o_fval=0, o_busy=0 at the next edge, then IDLE.
- Frame length from the first SG clock to the DONE clock = XSG_CYC + LINE_TOTAL*line period + 1; 1185 with defaults.
- Boundary conditions:
  - i_start while busy is ignored; no queuing.
  - i_start held high continuously gives back-to-back frames separated by one IDLE clock.
  - reset mid-frame aborts on the next edge to the reset values; no o_frame_done is issued.
  - A zero-valued dummy/black parameter is legal and simply removes that region.
  - IMAGE_WIDTH, IMAGE_HEIGHT, V_STEP_CYC and XSG_CYC must be at least 1; H_GAP_CYC may be 0, which skips HGAP.
- Counters are 16-bit. PIX_TOTAL and LINE_TOTAL must each be at most 65535 (elaboration check).

Decomposition:
- Shared package ccd_sharp_pkg holds:
  - state encoding;
  - the XV step patterns (XV_IDLE=4'b1100, XV_S1..XV_S3);
  - PIX_TOTAL / LINE_TOTAL derivation functions, also used by the sensor model and the capture stage.
- One sub-module: ccd_sharp_hclk_gen. It takes a run enable, produces h1/h2/hl/rs/o_lval/ov_pix_cnt, and reports line_end.
- The top keeps the frame FSM, the vertical step counter and the line counter.

Test Plan:
- Reset then one i_start pulse (defaults):
  - o_busy rises one clock later; xsg is low for exactly 8 clocks.
  - 12 lines follow, each 98 clocks; o_frame_done pulses 1185 clocks after SG entry.
- Per line:
  - xv steps 0110, 0011, 1001, 1100, 4 clocks each.
  - Then 2 idle clocks, then 40 o_lval pulses spaced 2 clocks apart, ov_pix_cnt 0..39.
  - h2 == ~h1 and hl == h1 on every clock.
- i_start pulsed mid-frame (line 5) -> no effect: still 12 lines, a single o_frame_done.
- reset asserted in HREAD of line 3 -> next clock all outputs at reset values; no o_frame_done; a later i_start gives a full, normal frame.
- i_start tied high -> consecutive frames; o_frame_done pulses 1186 clocks apart; o_busy low for exactly one clock between frames.
- Parameters DUMMY_VFRONT=0, H_GAP_CYC=0 -> LINE_TOTAL=11, line period 96; first pixel comes on the clock right after the VSHIFT step 1100.
